// File: rtl/multiplicador_secuencial.sv
// Sequential signed multiplier: shift-and-add on operand magnitudes over tamanyo cycles,
// with the sign applied in a dedicated state before the registered result is presented.
module multiplicador_secuencial #(
  parameter int tamanyo = 32
) (
  input  logic                   CLK,
  input  logic                   RSTa,
  input  logic                   Start,
  input  logic [tamanyo-1:0]     Multiplicando,
  input  logic [tamanyo-1:0]     Multiplicador,
  output logic [2*tamanyo-1:0]   Producto,
  output logic                   Done,
  output logic                   Busy
);

  localparam int CW = (tamanyo > 2) ? $clog2(tamanyo) : 1;

  typedef enum logic [1:0] {IDLE, CALC, SIGN, FIN} state_t;

  state_t                 state, next_state;
  logic [tamanyo-1:0]     a_mag;
  logic [2*tamanyo-1:0]   p;
  logic [CW-1:0]          cnt;
  logic                   sign_flag;
  logic [tamanyo-1:0]     a_abs, b_abs;
  logic [tamanyo:0]       sum;
  logic                   last_iter;

  // -2^(tamanyo-1) negates to itself, which reads correctly as an unsigned magnitude
  assign a_abs     = Multiplicando[tamanyo-1] ? -Multiplicando : Multiplicando;
  assign b_abs     = Multiplicador[tamanyo-1] ? -Multiplicador : Multiplicador;
  assign last_iter = (cnt == CW'(tamanyo - 1));

  always_comb begin
    sum = {1'b0, p[2*tamanyo-1:tamanyo]} + (p[0] ? {1'b0, a_mag} : '0);
  end

  always_ff @(posedge CLK or posedge RSTa) begin
    if (RSTa) state <= IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    Done       = 1'b0;
    Busy       = 1'b1;
    case (state)
      IDLE: begin
        Busy = 1'b0;
        if (Start) next_state = CALC;
      end
      CALC: if (last_iter) next_state = SIGN;
      SIGN: next_state = FIN;
      FIN: begin
        Done       = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RSTa) begin
    if (RSTa) begin
      a_mag     <= '0;
      p         <= '0;
      cnt       <= '0;
      sign_flag <= 1'b0;
      Producto  <= '0;
    end else begin
      case (state)
        IDLE: if (Start) begin
          a_mag     <= a_abs;
          p         <= {{tamanyo{1'b0}}, b_abs};
          cnt       <= '0;
          sign_flag <= Multiplicando[tamanyo-1] ^ Multiplicador[tamanyo-1];
        end
        CALC: begin
          // {carry, high half + addend, low half} shifted right by one
          p   <= {sum, p[tamanyo-1:1]};
          cnt <= cnt + 1'b1;
        end
        SIGN: Producto <= sign_flag ? -p : p;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multiplicador_secuencial.sv
// Scoreboard bench for multiplicador_secuencial at tamanyo=8: stimulus pushes expected
// products, a negedge monitor pops one on every Done pulse.
module tb_multiplicador_secuencial;

  localparam int T = 8;

  logic           CLK = 1'b0;
  logic           RSTa;
  logic           Start;
  logic [T-1:0]   a, b;
  logic [2*T-1:0] prod;
  logic           done, busy;

  int compared   = 0;
  int mismatched = 0;
  logic [2*T-1:0] exp_q[$];

  multiplicador_secuencial #(.tamanyo(T)) dut (
    .CLK          (CLK),
    .RSTa         (RSTa),
    .Start        (Start),
    .Multiplicando(a),
    .Multiplicador(b),
    .Producto     (prod),
    .Done         (done),
    .Busy         (busy)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  always @(negedge CLK) begin
    logic [2*T-1:0] e;
    if (!RSTa && done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'(done), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("producto", 32'(prod), 32'(e));
      end
    end
  end

  // One operation from IDLE; operands are scrambled after capture to show they are not needed.
  task automatic do_op(input logic [T-1:0] x, input logic [T-1:0] y, input logic [2*T-1:0] e);
    int first_done = -1;
    int n_done     = 0;
    int busy_bad   = 0;
    @(negedge CLK);
    a = x; b = y; Start = 1'b1;
    @(posedge CLK);
    exp_q.push_back(e);
    for (int k = 0; k <= 12; k++) begin
      @(negedge CLK);
      if (k == 0) begin
        Start = 1'b0;
        a = ~x;
        b = y + 8'd37;
      end
      if (done) begin
        if (first_done < 0) first_done = k;
        n_done++;
      end
      if (busy !== (k <= 9)) busy_bad++;
    end
    check("done_latency", 32'(first_done), 32'd9);
    check("done_pulses", 32'(n_done), 32'd1);
    check("busy_window", 32'(busy_bad), 32'd0);
    check("producto_hold", 32'(prod), 32'(e));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    logic signed [2*T-1:0] m;
    RSTa = 1'b0; Start = 1'b0; a = '0; b = '0;
    #1 RSTa = 1'b1;
    #1;
    check("reset_producto", 32'(prod), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge CLK);
    RSTa = 1'b0;

    do_op(8'd7,   8'd6,   16'h002A);
    do_op(8'hFD,  8'd5,   16'hFFF1);
    do_op(8'h80,  8'h80,  16'h4000);
    do_op(8'h80,  8'h7F,  16'hC080);
    do_op(8'h00,  8'hB3,  16'h0000);
    do_op(8'hFF,  8'hFF,  16'h0001);
    do_op(8'h7F,  8'h7F,  16'h3F01);
    do_op(8'h80,  8'h01,  16'hFF80);

    // Start held high, operands changing every cycle: captures at edges 0, 11, 22
    bad = 0;
    Start = 1'b1;
    for (int e = 0; e <= 32; e++) begin
      a = 8'(e * 29 + 3);
      b = 8'(200 - e * 17);
      if (e % 11 == 0) begin
        m = $signed(a) * $signed(b);
        exp_q.push_back(m);
      end
      @(negedge CLK);
      if (done !== (e % 11 == 9)) bad++;
    end
    Start = 1'b0;
    check("b2b_done_spacing", 32'(bad), 32'd0);
    repeat (2) @(negedge CLK);

    // Reset after the fourth CALC iteration aborts the operation
    a = 8'd100; b = 8'hFD; Start = 1'b1;
    @(posedge CLK);
    exp_q.push_back(16'hFED4);
    @(negedge CLK);
    Start = 1'b0;
    repeat (4) @(negedge CLK);
    RSTa = 1'b1;
    exp_q.delete();
    #1;
    check("abort_producto", 32'(prod), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    @(negedge CLK);
    RSTa = 1'b0;
    bad = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge CLK);
      if (done) bad++;
    end
    check("abort_no_done", 32'(bad), 32'd0);

    do_op(8'd100, 8'hFD, 16'hFED4);

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/multiplicador_secuencial.md
MULTIPLICADOR_SECUENCIAL -- requirements
Module: multiplicador_secuencial

Interface
REQ-001 SHALL have parameter: tamanyo, default 32, operand width in bits (minimum 2).
REQ-002 SHALL have port: CLK  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port: RSTa  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port: Start  input  1  request to begin an operation; sampled only in IDLE.
REQ-005 SHALL have port: Multiplicando  input  tamanyo  signed two's-complement operand A.
REQ-006 SHALL have port: Multiplicador  input  tamanyo  signed two's-complement operand B.
REQ-007 SHALL have port: Producto  output  2*tamanyo  signed two's-complement result A*B, registered.
REQ-008 SHALL have port: Done  output  1  one-cycle pulse marking Producto as newly valid.
REQ-009 SHALL have port: Busy  output  1  high in every state other than IDLE.

Function
REQ-010 SHALL implement the FSM states IDLE, CALC, SIGN and FIN.
REQ-011 SHALL, in IDLE with Start=1 at edge t, capture |A| and |B| (tamanyo-bit unsigned) and sign flag = A[msb] XOR B[msb]; clear accumulator high half and the iteration counter; enter CALC.
REQ-012 SHALL ignore operand input changes after the capture edge; operands need not be held.
REQ-013 SHALL, on each CALC edge: if P[0]=1, add |A| to the high half of P with a (tamanyo+1)-bit carry; shift {carry,P} right by one; increment the counter.
REQ-014 SHALL leave CALC for SIGN at edge t+tamanyo, after exactly tamanyo iterations.
REQ-015 SHALL, at SIGN edge t+tamanyo+1, load Producto with P, or with two's-complement negation of P when the sign flag is 1; enter FIN.
REQ-016 SHALL assert Done=1 for exactly the cycle spent in FIN, then return to IDLE at edge t+tamanyo+2.
REQ-017 SHALL hold Producto unchanged from FIN until the next SIGN state or reset.
REQ-018 SHALL ignore Start in CALC, SIGN and FIN: no queuing, no restart.
REQ-019 SHALL, with Start held high continuously, begin the next operation on the first IDLE edge, giving back-to-back results every tamanyo+3 cycles.
REQ-020 SHALL produce an exact result for A or B = -2^(tamanyo-1): |x| = 2^(tamanyo-1) is representable unsigned, and (-2^(tamanyo-1))^2 fits in 2*tamanyo signed bits.
REQ-021 SHALL yield Producto=0 when either operand is 0, regardless of the sign flag, since negating 0 gives 0.
REQ-022 SHALL compute all intermediate arithmetic unsigned on the magnitudes, applying sign only in SIGN; no overflow is possible.

Reset
REQ-023 SHALL, while RSTa=1 and independent of CLK, force state=IDLE, Producto=0, Done=0, Busy=0, and clear all internal registers.
REQ-024 SHALL, on reset in any state including mid-CALC, abort the operation with no Done pulse; the first Start after RSTa deasserts starts a fresh operation.
REQ-025 SHALL not sample Start on an edge where RSTa=1.

Verification (tamanyo=8)
REQ-026 SHALL cover: A=7, B=6, Start pulse at edge t -> Busy from t, Done high only in cycle after edge t+9, Producto=0x002A.
REQ-027 SHALL cover: A=-3 (0xFD), B=5 -> Producto=0xFFF1 (-15) with one Done pulse.
REQ-028 SHALL cover: A=B=-128 (0x80) -> Producto=0x4000 (16384); and A=-128, B=127 -> 0xC080 (-16256).
REQ-029 SHALL cover: A=0, B=-77 -> Producto=0x0000; and A=-1, B=-1 -> 0x0001.
REQ-030 SHALL cover: Start held high, operands changed every cycle -> results appear every 11 cycles, each equal to the operands present at its own capture edge.
REQ-031 SHALL cover: RSTa pulsed at CALC iteration 4 -> immediate Producto=0, Busy=0, no Done; a new Start afterwards gives the correct result with full latency.
